ma_stage: RTL

Memory-access stage of the 32-bit in-order pipeline, between execute and writeback. Accepts one `Ex_Ma_t` payload at a time and performs the load or store on the data-memory request/grant/response port. Produces the registered `Ma_Wb_t` payload and `Ma_Valid` consumed by writeback, and back-pressures execute while a memory access is in flight.

---
 rtl/ma_stage_if.sv | 59 +++++
 rtl/ma_stage.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ma_stage_if.sv
// Payload types and the execute/writeback/data-memory bus seen by the memory-access stage.
// The stage side takes the master modport; the surrounding pipeline and memory take the slave modport.
package ma_stage_pkg;

    typedef struct packed {
        logic isLd;
        logic isSt;
        logic isCall;
        logic isWb;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu_result;
        logic [31:0] op2;
        ctrl_t       ctrl;
    } Ex_Ma_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] alu_result;
        logic [31:0] ld_load;
        ctrl_t       ctrl;
    } Ma_Wb_t;

endpackage

interface ma_stage_if;
    import ma_stage_pkg::*;

    Ex_Ma_t      Ex_Payld;
    logic        Ex_Valid;
    logic        Ma_Ready;
    Ma_Wb_t      Ma_Payld;
    logic        Ma_Valid;
    logic        ma_err;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        input  Ex_Payld, Ex_Valid, dmem_gnt, dmem_rvalid, dmem_rdata,
        output Ma_Ready, Ma_Payld, Ma_Valid, ma_err,
               dmem_req, dmem_we, dmem_addr, dmem_wdata
    );

    modport slave (
        output Ex_Payld, Ex_Valid, dmem_gnt, dmem_rvalid, dmem_rdata,
        input  Ma_Ready, Ma_Payld, Ma_Valid, ma_err,
               dmem_req, dmem_we, dmem_addr, dmem_wdata
    );

endinterface

// File: rtl/ma_stage.sv
// Memory-access pipeline stage: performs one load/store at a time on the request/grant/response
// data-memory port and hands a registered payload to writeback.
module ma_stage
    import ma_stage_pkg::*;
#(
    parameter int RSP_TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Start,
    ma_stage_if.master   bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

    state_t      state;
    state_t      state_nxt;
    Ex_Ma_t      hold;
    logic [7:0]  cnt;
    logic        stale_rsp;

    logic        accept;
    logic        ex_mem;
    logic        ex_misaligned;
    logic        rsp_ok;
    logic        timeout;

    // A load wins when both memory bits are set, so the store bit is dropped before anything sees it.
    function automatic Ex_Ma_t normalize(input Ex_Ma_t e);
        Ex_Ma_t r;
        r = e;
        if (e.ctrl.isLd) r.ctrl.isSt = 1'b0;
        return r;
    endfunction

    function automatic Ma_Wb_t to_wb(input Ex_Ma_t e, input logic [31:0] ld, input logic err);
        Ma_Wb_t r;
        r.pc          = e.pc;
        r.instr       = e.instr;
        r.alu_result  = e.alu_result;
        r.ld_load     = ld;
        r.ctrl        = e.ctrl;
        r.ctrl.isWb   = e.ctrl.isWb && !err;
        return r;
    endfunction

    assign accept        = bus.Ex_Valid && bus.Ma_Ready;
    assign ex_mem        = bus.Ex_Payld.ctrl.isLd || bus.Ex_Payld.ctrl.isSt;
    assign ex_misaligned = (bus.Ex_Payld.alu_result[1:0] != 2'b00);
    assign rsp_ok        = (state == WAIT_RSP) && bus.dmem_rvalid && !stale_rsp;
    assign timeout       = (state == WAIT_RSP) && !rsp_ok && (cnt == 8'(RSP_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept && ex_mem && !ex_misaligned) state_nxt = REQ;
            REQ:      if (bus.dmem_gnt) state_nxt = hold.ctrl.isLd ? WAIT_RSP : IDLE;
            WAIT_RSP: if (rsp_ok || timeout) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Memory-side outputs come only from registered state so the memory sees stable values until grant.
    always_comb begin
        bus.Ma_Ready   = Start && !rst && (state == IDLE);
        bus.dmem_req   = (state == REQ);
        bus.dmem_we    = (state == REQ) && hold.ctrl.isSt && !hold.ctrl.isLd;
        bus.dmem_addr  = (state == REQ) ? hold.alu_result : 32'h0;
        bus.dmem_wdata = bus.dmem_we ? hold.op2 : 32'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold         <= '0;
            cnt          <= 8'd0;
            stale_rsp    <= 1'b0;
            bus.Ma_Payld <= '0;
            bus.Ma_Valid <= 1'b0;
            bus.ma_err   <= 1'b0;
        end else begin
            bus.Ma_Valid <= 1'b0;
            bus.ma_err   <= 1'b0;
            // A response for an abandoned load may still arrive; swallow exactly one.
            if (bus.dmem_rvalid && stale_rsp) stale_rsp <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!ex_mem) begin
                            bus.Ma_Payld <= to_wb(bus.Ex_Payld, 32'h0, 1'b0);
                            bus.Ma_Valid <= 1'b1;
                        end else if (ex_misaligned) begin
                            bus.Ma_Payld <= to_wb(normalize(bus.Ex_Payld), 32'h0, 1'b1);
                            bus.Ma_Valid <= 1'b1;
                            bus.ma_err   <= 1'b1;
                        end else begin
                            hold <= normalize(bus.Ex_Payld);
                        end
                    end
                end
                REQ: begin
                    if (bus.dmem_gnt) begin
                        if (hold.ctrl.isLd) begin
                            cnt <= 8'd0;
                        end else begin
                            bus.Ma_Payld <= to_wb(hold, 32'h0, 1'b0);
                            bus.Ma_Valid <= 1'b1;
                        end
                    end
                end
                WAIT_RSP: begin
                    if (rsp_ok) begin
                        bus.Ma_Payld <= to_wb(hold, bus.dmem_rdata, 1'b0);
                        bus.Ma_Valid <= 1'b1;
                    end else if (timeout) begin
                        bus.Ma_Payld <= to_wb(hold, 32'h0, 1'b1);
                        bus.Ma_Valid <= 1'b1;
                        bus.ma_err   <= 1'b1;
                        stale_rsp    <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
